// File: rtl/key_evt_pkg.sv
// rtl/key_evt_pkg.sv - shared types and helpers for the key event decoder
//
// Contents:
//   evt_type_t   event codes presented on evt_type (SHORT, DOUBLE, LONG, REPEAT)
//   chan_state_t per-key classifier states
//   KEY_IDX_W    width of the evt_key index
//   ms2ticks     clock cycles in a given number of milliseconds (never below 1)
//   max3         largest of three integers, used to size channel timers
package key_evt_pkg;

   typedef enum logic [1:0] {
      EVT_SHORT  = 2'd0,
      EVT_DOUBLE = 2'd1,
      EVT_LONG   = 2'd2,
      EVT_REPEAT = 2'd3
   } evt_type_t;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HOLD  = 3'd1,
      LHOLD = 3'd2,
      GAP   = 3'd3,
      DHOLD = 3'd4
   } chan_state_t;

   localparam int KEY_IDX_W = 2;

   function automatic int ms2ticks(input int clk_freq, input int ms);
      int t;
      t = (clk_freq / 1000) * ms;
      return (t < 1) ? 1 : t;
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/key_evt_chan.sv
// rtl/key_evt_chan.sv - one key channel: edge detect, classifier FSM, ms timer, emit strobe
//
// Optional feature macro: KEY_EVT_REPEAT_EN (REPEAT emission while held after LONG).
//
// Ports:
//   clk        in   1           system clock
//   rst        in   1           asynchronous, active-high reset
//   key_in     in   1           debounced key level, active-low (0 = pressed)
//   ms_tick    in   1           one-cycle strobe per millisecond, shared by all channels
//   emit       out  1           combinational strobe: an event is produced this cycle
//   emit_type  out  evt_type_t  code of the event produced this cycle
module key_evt_chan
   import key_evt_pkg::*;
#(
   parameter int LONG_MS   = 1000,
   parameter int DBL_MS    = 300,
   parameter int REPEAT_MS = 200
)(
   input  logic      clk,
   input  logic      rst,
   input  logic      key_in,
   input  logic      ms_tick,
   output logic      emit,
   output evt_type_t emit_type
);

   localparam int T_MAX = max3(LONG_MS, DBL_MS, REPEAT_MS);
   localparam int TMR_W = $clog2(T_MAX + 1);

   chan_state_t      state;
   chan_state_t      state_nxt;
   logic             key_prev;
   logic             press;
   logic             release_edge;
   logic [TMR_W-1:0] timer;
   logic             timer_clr;

   // History resets to "pressed" so a key held through reset cannot
   // produce a press edge until it has been released first.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) key_prev <= 1'b0;
      else     key_prev <= key_in;
   end

   assign press        = key_prev & ~key_in;
   assign release_edge = ~key_prev & key_in;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Counts ms ticks since the last state entry (or last REPEAT); saturates.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                      timer <= '0;
      else if (timer_clr)           timer <= '0;
      else if (ms_tick && !(&timer)) timer <= timer + 1'b1;
   end

   // A limit is hit on the tick that would take the timer to that value,
   // so the strobe lands in the same cycle as the expiring tick.
   // Key edges take priority over a coincident expiry.
   always_comb begin
      state_nxt = state;
      timer_clr = 1'b0;
      emit      = 1'b0;
      emit_type = EVT_SHORT;
      case (state)
         IDLE: begin
            if (press) begin
               state_nxt = HOLD;
               timer_clr = 1'b1;
            end
         end
         HOLD: begin
            if (release_edge) begin
               state_nxt = GAP;
               timer_clr = 1'b1;
            end else if (ms_tick && timer == TMR_W'(LONG_MS - 1)) begin
               emit      = 1'b1;
               emit_type = EVT_LONG;
               state_nxt = LHOLD;
               timer_clr = 1'b1;
            end
         end
         LHOLD: begin
            if (release_edge) begin
               state_nxt = IDLE;
               timer_clr = 1'b1;
`ifdef KEY_EVT_REPEAT_EN
            end else if (ms_tick && timer == TMR_W'(REPEAT_MS - 1)) begin
               emit      = 1'b1;
               emit_type = EVT_REPEAT;
               timer_clr = 1'b1;
`endif
            end
         end
         GAP: begin
            if (press) begin
               emit      = 1'b1;
               emit_type = EVT_DOUBLE;
               state_nxt = DHOLD;
               timer_clr = 1'b1;
            end else if (ms_tick && timer == TMR_W'(DBL_MS - 1)) begin
               emit      = 1'b1;
               emit_type = EVT_SHORT;
               state_nxt = IDLE;
               timer_clr = 1'b1;
            end
         end
         DHOLD: begin
            if (release_edge) begin
               state_nxt = IDLE;
               timer_clr = 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            timer_clr = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/key_event_decoder.sv
// rtl/key_event_decoder.sv - classifies debounced keys into events and serialises them on valid/ready
//
// Optional feature macro: KEY_EVT_REPEAT_EN (REPEAT events while a key stays held after LONG).
//
// Ports:
//   clk          in   1      system clock
//   rst          in   1      asynchronous, active-high reset
//   key_in       in   KEY_W  debounced key levels, active-low (0 = pressed)
//   evt_ready    in   1      consumer accepts the presented event
//   evt_valid    out  1      an event is presented
//   evt_key      out  2      index of the key owning the event
//   evt_type     out  2      0 SHORT, 1 DOUBLE, 2 LONG, 3 REPEAT
//   err_overrun  out  1      sticky: a pending event was overwritten before acceptance
module key_event_decoder
   import key_evt_pkg::*;
#(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int LONG_MS   = 1000,
   parameter int DBL_MS    = 300,
   parameter int REPEAT_MS = 200,
   parameter int KEY_W     = 3
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [KEY_W-1:0]     key_in,
   input  logic                 evt_ready,
   output logic                 evt_valid,
   output logic [KEY_IDX_W-1:0] evt_key,
   output logic [1:0]           evt_type,
   output logic                 err_overrun
);

   localparam int DIV     = ms2ticks(CLK_FREQ, 1);
   localparam int PRESC_W = (DIV > 1) ? $clog2(DIV) : 1;

   logic [PRESC_W-1:0]   presc;
   logic                 ms_tick;
   logic [KEY_W-1:0]     emit;
   evt_type_t            emit_type [KEY_W];
   logic [KEY_W-1:0]     pend;
   evt_type_t            ptype [KEY_W];
   logic [KEY_W-1:0]     acc_vec;
   logic [KEY_IDX_W-1:0] sel_idx;
   evt_type_t            sel_type;
   logic                 sel_any;

   // Free-running millisecond prescaler shared by every channel.
   assign ms_tick = (presc == PRESC_W'(DIV - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)          presc <= '0;
      else if (ms_tick) presc <= '0;
      else              presc <= presc + 1'b1;
   end

   for (genvar g = 0; g < KEY_W; g++) begin : g_chan
      key_evt_chan #(
         .LONG_MS   (LONG_MS),
         .DBL_MS    (DBL_MS),
         .REPEAT_MS (REPEAT_MS)
      ) u_chan (
         .clk       (clk),
         .rst       (rst),
         .key_in    (key_in[g]),
         .ms_tick   (ms_tick),
         .emit      (emit[g]),
         .emit_type (emit_type[g])
      );
   end

   // Lowest pending index wins.
   always_comb begin
      sel_idx  = '0;
      sel_type = EVT_SHORT;
      sel_any  = 1'b0;
      for (int i = KEY_W - 1; i >= 0; i--) begin
         if (pend[i]) begin
            sel_idx  = KEY_IDX_W'(i);
            sel_type = ptype[i];
            sel_any  = 1'b1;
         end
      end
   end

   always_comb begin
      acc_vec = '0;
      for (int i = 0; i < KEY_W; i++) begin
         acc_vec[i] = evt_valid && evt_ready && (evt_key == KEY_IDX_W'(i));
      end
   end

   // A new emission always wins over a same-cycle accept of that slot;
   // it only counts as an overrun when the old event was not being taken.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend        <= '0;
         err_overrun <= 1'b0;
         for (int i = 0; i < KEY_W; i++) ptype[i] <= EVT_SHORT;
      end else begin
         for (int i = 0; i < KEY_W; i++) begin
            if (emit[i]) begin
               pend[i]  <= 1'b1;
               ptype[i] <= emit_type[i];
            end else if (acc_vec[i]) begin
               pend[i] <= 1'b0;
            end
         end
         if (|(emit & pend & ~acc_vec)) err_overrun <= 1'b1;
      end
   end

   // Presented event is frozen while stalled. After an accept there is a
   // one-cycle bubble so the cleared slot is never presented twice.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         evt_valid <= 1'b0;
         evt_key   <= '0;
         evt_type  <= 2'd0;
      end else if (evt_valid && evt_ready) begin
         evt_valid <= 1'b0;
      end else if (!evt_valid && sel_any) begin
         evt_valid <= 1'b1;
         evt_key   <= sel_idx;
         evt_type  <= sel_type;
      end
   end

endmodule

// File: tb/tb_key_event_decoder.sv
// tb/tb_key_event_decoder.sv - randomized self-checking bench for key_event_decoder
module tb_key_event_decoder;

   localparam int CLK_FREQ  = 1000;
   localparam int LONG_MS   = 20;
   localparam int DBL_MS    = 8;
   localparam int REPEAT_MS = 5;
   localparam int KEY_W     = 3;
`ifdef KEY_EVT_REPEAT_EN
   localparam bit REP_EN = 1'b1;
`else
   localparam bit REP_EN = 1'b0;
`endif
   localparam int T_SHORT  = 0;
   localparam int T_DOUBLE = 1;
   localparam int T_LONG   = 2;
   localparam int T_REPEAT = 3;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [KEY_W-1:0] key_in = '1;
   logic             evt_ready = 1'b0;
   logic             evt_valid;
   logic [1:0]       evt_key;
   logic [1:0]       evt_type;
   logic             err_overrun;

   key_event_decoder #(
      .CLK_FREQ  (CLK_FREQ),
      .LONG_MS   (LONG_MS),
      .DBL_MS    (DBL_MS),
      .REPEAT_MS (REPEAT_MS),
      .KEY_W     (KEY_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .key_in      (key_in),
      .evt_ready   (evt_ready),
      .evt_valid   (evt_valid),
      .evt_key     (evt_key),
      .evt_type    (evt_type),
      .err_overrun (err_overrun)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input int exp);
      total++;
      if (got !== 32'(exp)) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: classification from press/release timestamps,
   // plus one pending slot per key and a single presented event.
   int         cyc = 0;
   logic [2:0] m_lvl;
   int         m_press_t [3];
   int         m_gap_t   [3];
   bit         m_longed  [3];
   bit         m_dbl     [3];
   bit         m_pend    [3];
   int         m_ptype   [3];
   bit         m_valid;
   int         m_key;
   int         m_type;
   bit         m_ovr;

   task automatic model_reset();
      m_lvl = 3'b000;
      for (int k = 0; k < 3; k++) begin
         m_press_t[k] = -1;
         m_gap_t[k]   = -1;
         m_longed[k]  = 1'b0;
         m_dbl[k]     = 1'b0;
         m_pend[k]    = 1'b0;
         m_ptype[k]   = 0;
      end
      m_valid = 1'b0;
      m_key   = 0;
      m_type  = 0;
      m_ovr   = 1'b0;
   endtask

   task automatic model_step(input logic [2:0] kv, input logic rv);
      bit em [3];
      int et [3];
      bit pr, rl, acc;
      int old_key;
      cyc++;
      for (int k = 0; k < 3; k++) begin
         em[k] = 1'b0;
         et[k] = 0;
         pr = m_lvl[k] && !kv[k];
         rl = !m_lvl[k] && kv[k];
         if (m_gap_t[k] >= 0) begin
            if (pr) begin
               em[k] = 1'b1; et[k] = T_DOUBLE; m_gap_t[k] = -1; m_dbl[k] = 1'b1;
            end else if (cyc - m_gap_t[k] == DBL_MS) begin
               em[k] = 1'b1; et[k] = T_SHORT; m_gap_t[k] = -1;
            end
         end else if (m_dbl[k]) begin
            if (rl) m_dbl[k] = 1'b0;
         end else if (m_press_t[k] >= 0) begin
            if (rl) begin
               if (!m_longed[k]) m_gap_t[k] = cyc;
               m_press_t[k] = -1;
               m_longed[k]  = 1'b0;
            end else if (!m_longed[k] && cyc - m_press_t[k] == LONG_MS) begin
               em[k] = 1'b1; et[k] = T_LONG; m_longed[k] = 1'b1;
            end else if (REP_EN && m_longed[k] &&
                         (cyc - m_press_t[k] - LONG_MS) % REPEAT_MS == 0) begin
               em[k] = 1'b1; et[k] = T_REPEAT;
            end
         end else if (pr) begin
            m_press_t[k] = cyc;
         end
      end
      m_lvl = kv;

      acc     = m_valid && rv;
      old_key = m_key;
      if (acc) begin
         m_valid = 1'b0;
      end else if (!m_valid) begin
         for (int k = 2; k >= 0; k--) begin
            if (m_pend[k]) begin
               m_valid = 1'b1; m_key = k; m_type = m_ptype[k];
            end
         end
      end
      for (int k = 0; k < 3; k++) begin
         if (em[k]) begin
            if (m_pend[k] && !(acc && old_key == k)) m_ovr = 1'b1;
            m_pend[k]  = 1'b1;
            m_ptype[k] = et[k];
         end else if (acc && old_key == k) begin
            m_pend[k] = 1'b0;
         end
      end
   endtask

   task automatic tick(input logic [2:0] kv, input logic rv);
      key_in    = kv;
      evt_ready = rv;
      model_step(kv, rv);
      @(posedge clk);
      @(negedge clk);
      check("valid", 32'(evt_valid), int'(m_valid));
      if (m_valid) begin
         check("key", 32'(evt_key), m_key);
         check("type", 32'(evt_type), m_type);
      end
      check("overrun", 32'(err_overrun), int'(m_ovr));
   endtask

   task automatic run(input logic [2:0] kv, input logic rv, input int n);
      for (int i = 0; i < n; i++) tick(kv, rv);
   endtask

   task automatic do_reset(input logic [2:0] kv);
      rst       = 1'b1;
      key_in    = kv;
      evt_ready = 1'b0;
      model_reset();
      @(posedge clk);
      @(negedge clk);
      check("rst_valid", 32'(evt_valid), 0);
      check("rst_key", 32'(evt_key), 0);
      check("rst_type", 32'(evt_type), 0);
      check("rst_overrun", 32'(err_overrun), 0);
      rst = 1'b0;
   endtask

   function automatic int pick_len();
      case ($urandom_range(0, 5))
         0:       return int'($urandom_range(1, 4));
         1:       return int'($urandom_range(5, 10));
         2:       return int'($urandom_range(18, 23));
         3:       return int'($urandom_range(24, 40));
         4:       return int'($urandom_range(1, 12));
         default: return int'($urandom_range(40, 70));
      endcase
   endfunction

   initial begin
      int         rem [3];
      logic [2:0] lv;
      int         stall;
      logic       r;

      // key0 held through reset release, then released: no event
      do_reset(3'b110);
      run(3'b110, 1'b1, 25);
      run(3'b111, 1'b1, 12);
      check("held_reset_no_evt", 32'(evt_valid), 0);

      // SHORT on key0
      run(3'b110, 1'b0, 5);
      tick(3'b111, 1'b0);
      run(3'b111, 1'b0, 9);
      check("short_valid", 32'(evt_valid), 1);
      check("short_key", 32'(evt_key), 0);
      check("short_type", 32'(evt_type), T_SHORT);
      run(3'b111, 1'b1, 4);
      check("short_drained", 32'(evt_valid), 0);

      // DOUBLE on key1, no trailing SHORT
      run(3'b101, 1'b0, 5);
      run(3'b111, 1'b0, 3);
      tick(3'b101, 1'b0);
      tick(3'b101, 1'b0);
      check("double_valid", 32'(evt_valid), 1);
      check("double_key", 32'(evt_key), 1);
      check("double_type", 32'(evt_type), T_DOUBLE);
      run(3'b101, 1'b0, 2);
      run(3'b111, 1'b1, 15);
      check("no_short_after_double", 32'(evt_valid), 0);

      // key2 held 32 cycles: LONG, then REPEATs when enabled
      run(3'b011, 1'b1, 32);
      run(3'b111, 1'b1, 15);

      // key0 and key2 LONG in the same cycle while stalled
      run(3'b010, 1'b0, 22);
      run(3'b111, 1'b0, 10);
      check("dual_valid", 32'(evt_valid), 1);
      check("dual_key", 32'(evt_key), 0);
      check("dual_type", 32'(evt_type), T_LONG);
      run(3'b111, 1'b1, 10);
      check("dual_drained", 32'(evt_valid), 0);
      check("dual_no_overrun", 32'(err_overrun), 0);

      // two LONGs on key2 without acceptance: overrun
      run(3'b011, 1'b0, 22);
      run(3'b111, 1'b0, 3);
      run(3'b011, 1'b0, 22);
      run(3'b111, 1'b0, 5);
      check("ovr_flag", 32'(err_overrun), 1);
      check("ovr_key", 32'(evt_key), 2);
      run(3'b111, 1'b1, 10);

      // reset during GAP: no SHORT afterwards
      run(3'b101, 1'b1, 5);
      run(3'b111, 1'b1, 3);
      do_reset(3'b111);
      run(3'b111, 1'b1, 15);
      check("gap_reset_no_short", 32'(evt_valid), 0);

      // randomized key activity with random back-pressure and rare resets
      lv    = 3'b111;
      stall = 0;
      for (int k = 0; k < 3; k++) rem[k] = pick_len();
      for (int c = 0; c < 4000; c++) begin
         for (int k = 0; k < 3; k++) begin
            if (rem[k] == 0) begin
               lv[k]  = ~lv[k];
               rem[k] = pick_len();
            end else begin
               rem[k]--;
            end
         end
         if (stall > 0) begin
            stall--;
            r = 1'b0;
         end else begin
            if ($urandom_range(0, 19) == 0) stall = int'($urandom_range(3, 30));
            r = ($urandom_range(0, 3) != 0);
         end
         if ($urandom_range(0, 1499) == 0) do_reset(lv);
         else                              tick(lv, r);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
